// File: rtl/btn_debouncer_multi.sv
// rtl/btn_debouncer_multi.sv - multi-channel button debouncer with press/release/long-press events
// Optional auto-repeat: define AUTO_REPEAT_EN to enable repeat_pulse generation.
module btn_debouncer_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 1048575,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    // One shared width sized for the largest count so no counter can wrap.
    localparam int MAX_SH = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_SH > REPEAT_CYCLES) ? MAX_SH : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_SAT    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [N_CH-1:0] sync_ff1;
    logic [N_CH-1:0] sync_ff2;
    logic [CW-1:0]   stab_cnt [N_CH];
    logic [CW-1:0]   hold_cnt [N_CH];
    logic [N_CH-1:0] accept;

    // accept marks the edge on which a channel's debounced level toggles.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (sync_ff2[i] != btn_level[i]) && (stab_cnt[i] == STABLE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff1      <= '0;
            sync_ff2      <= '0;
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stab_cnt[i] <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync_ff1 <= btn_in;
            sync_ff2 <= sync_ff1;
            for (int i = 0; i < N_CH; i++) begin
                press_pulse[i]   <= accept[i] && !btn_level[i];
                release_pulse[i] <= accept[i] && btn_level[i];

                if (accept[i]) begin
                    btn_level[i] <= ~btn_level[i];
                    stab_cnt[i]  <= '0;
                end else if (sync_ff2[i] != btn_level[i]) begin
                    stab_cnt[i] <= stab_cnt[i] + CNT_ONE;
                end else begin
                    stab_cnt[i] <= '0;
                end

                // A releasing edge clears hold progress so no long event lands on it.
                if (!btn_level[i] || accept[i]) begin
                    hold_cnt[i]   <= '0;
                    long_pulse[i] <= 1'b0;
                end else begin
                    if (hold_cnt[i] != HOLD_SAT) begin
                        hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
                    end
                    long_pulse[i] <= (hold_cnt[i] == HOLD_LAST);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] rep_cnt [N_CH];

    // Repeat phase starts from the long-press edge and runs while the hold counter is saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!btn_level[i] || accept[i] || hold_cnt[i] == HOLD_LAST) begin
                    rep_cnt[i]      <= '0;
                    repeat_pulse[i] <= 1'b0;
                end else if (hold_cnt[i] == HOLD_SAT) begin
                    if (rep_cnt[i] == REPEAT_LAST) begin
                        rep_cnt[i]      <= '0;
                        repeat_pulse[i] <= 1'b1;
                    end else begin
                        rep_cnt[i]      <= rep_cnt[i] + CNT_ONE;
                        repeat_pulse[i] <= 1'b0;
                    end
                end else begin
                    repeat_pulse[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// tb/tb_btn_debouncer_multi.sv - directed self-checking bench for btn_debouncer_multi
module tb_btn_debouncer_multi;

    localparam int N_CH          = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int HOLD_CYCLES   = 20;
    localparam int REPEAT_CYCLES = 5;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    int errors = 0;
    int checks = 0;

    btn_debouncer_multi #(
        .N_CH(N_CH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 2'b00;
        step();
        step();
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 0", {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        rst = 1'b0;
        step();
    endtask

    // ch0 press accepted at edge 6, then held 40 edges for long/repeat events, then released.
    task automatic test_press_hold_release();
        logic [1:0] exp_rep;
        btn_in = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++;
            if (press_pulse !== ((e == 6) ? 2'b01 : 2'b00) || btn_level !== ((e == 6) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL press_latency e=%0d: press=%b level=%b", e, press_pulse, btn_level);
            end
        end
        for (int t = 1; t <= 40; t++) begin
            step();
`ifdef AUTO_REPEAT_EN
            exp_rep = (t > 20 && (t % 5) == 0) ? 2'b01 : 2'b00;
`else
            exp_rep = 2'b00;
`endif
            checks++;
            if (long_pulse !== ((t == 20) ? 2'b01 : 2'b00) || repeat_pulse !== exp_rep ||
                press_pulse !== 2'b00 || btn_level !== 2'b01) begin
                errors++;
                $display("FAIL hold t=%0d: long=%b repeat=%b press=%b level=%b, want long=%b repeat=%b",
                         t, long_pulse, repeat_pulse, press_pulse, btn_level, (t == 20) ? 2'b01 : 2'b00, exp_rep);
            end
        end
        btn_in = 2'b00;
        for (int e = 1; e <= 9; e++) begin
            step();
`ifdef AUTO_REPEAT_EN
            exp_rep = (e == 5) ? 2'b01 : 2'b00;
`else
            exp_rep = 2'b00;
`endif
            checks++;
            if (release_pulse !== ((e == 6) ? 2'b01 : 2'b00) || btn_level !== ((e >= 6) ? 2'b00 : 2'b01) ||
                long_pulse !== 2'b00 || repeat_pulse !== exp_rep) begin
                errors++;
                $display("FAIL release e=%0d: release=%b level=%b long=%b repeat=%b", e, release_pulse, btn_level, long_pulse, repeat_pulse);
            end
        end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 5; c++) begin
                btn_in = (c < 3) ? 2'b10 : 2'b00;
                step();
                checks++;
                if ({btn_level, press_pulse, release_pulse, long_pulse} !== 8'b0) begin
                    errors++;
                    $display("FAIL glitch g=%0d c=%0d: level=%b press=%b release=%b", g, c, btn_level, press_pulse, release_pulse);
                end
            end
        end
        for (int e = 0; e < 6; e++) begin
            step();
            checks++;
            if ({btn_level, press_pulse, release_pulse} !== 6'b0) begin
                errors++;
                $display("FAIL glitch_tail e=%0d: level=%b press=%b release=%b", e, btn_level, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        btn_in = 2'b11;
        for (int e = 1; e <= 6; e++) begin
            step();
            checks++;
            if (press_pulse !== ((e == 6) ? 2'b11 : 2'b00) || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL both_press e=%0d: press=%b release=%b", e, press_pulse, release_pulse);
            end
        end
        for (int e = 0; e < 5; e++) step();
        btn_in = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (release_pulse !== ((e == 6) ? 2'b11 : 2'b00) || press_pulse !== 2'b00 || long_pulse !== 2'b00) begin
                errors++;
                $display("FAIL both_release e=%0d: release=%b press=%b long=%b", e, release_pulse, press_pulse, long_pulse);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        btn_in = 2'b01;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({btn_level, press_pulse, release_pulse} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: level=%b press=%b release=%b, want 0", btn_level, press_pulse, release_pulse);
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (press_pulse !== ((e == 6) ? 2'b01 : 2'b00) || btn_level !== ((e >= 6) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL post_reset_press e=%0d: press=%b level=%b", e, press_pulse, btn_level);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        test_reset();
        test_press_hold_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debouncer_multi.md
BTN_DEBOUNCER_MULTI -- requirements
Module: btn_debouncer_multi

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of independent button channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 1048575, SHALL set the consecutive stable cycles needed to accept a level change (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50000000, SHALL set the accepted-high cycles before a long-press event (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 10000000, SHALL set the auto-repeat period after a long press (>=1).
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 btn_in  input  N_CH  raw asynchronous button inputs, active-high.
REQ-008 btn_level  output  N_CH  debounced level per channel.
REQ-009 press_pulse  output  N_CH  one-cycle pulse per accepted 0->1 change.
REQ-010 release_pulse  output  N_CH  one-cycle pulse per accepted 1->0 change.
REQ-011 long_pulse  output  N_CH  one-cycle pulse when held HOLD_CYCLES.
REQ-012 repeat_pulse  output  N_CH  one-cycle auto-repeat pulses (see Configuration).

Function
REQ-013 Each btn_in bit SHALL pass a 2-flop synchronizer; only the second flop's output (sync) feeds the debounce logic.
REQ-014 Per channel, a stability counter SHALL increment each cycle sync != btn_level and clear to 0 any cycle sync == btn_level.
REQ-015 When the counter equals STABLE_CYCLES-1 and sync != btn_level, the next edge SHALL toggle btn_level, clear the counter, and assert press_pulse (new level 1) or release_pulse (new level 0) for exactly that one cycle.
REQ-016 Latency: a btn_in change held stable SHALL appear on btn_level exactly STABLE_CYCLES+2 edges after the first edge sampling it.
REQ-017 Any glitch shorter than STABLE_CYCLES synchronized cycles SHALL produce no change and no pulse.
REQ-018 A hold counter per channel SHALL count cycles btn_level==1, clear when btn_level==0, and saturate after HOLD_CYCLES.
REQ-019 long_pulse SHALL assert for one cycle when the hold counter reaches HOLD_CYCLES, at most once per accepted press.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-021 press_pulse and release_pulse on one channel SHALL never assert together; long_pulse and repeat_pulse SHALL never assert in the release_pulse cycle.
REQ-022 Counter widths SHALL be $clog2 of the largest parameter +1, with no wrap-around at any parameter value.

Reset
REQ-023 With rst high at an edge, synchronizers, all counters, btn_level and all pulse outputs SHALL be 0 on the next cycle.
REQ-024 Reset mid-debounce or mid-hold SHALL discard progress; a button held through reset release SHALL yield press_pulse STABLE_CYCLES+2 edges after rst deasserts.
REQ-025 All outputs SHALL be registered; no output SHALL depend combinationally on btn_in or rst.

Configuration
REQ-026 With macro AUTO_REPEAT_EN defined, after long_pulse, repeat_pulse SHALL assert for one cycle every REPEAT_CYCLES cycles while btn_level stays 1, stopping when btn_level goes 0.
REQ-027 Without AUTO_REPEAT_EN, repeat_pulse SHALL be constant 0 and no repeat counters SHALL be synthesised; all other behaviour is unchanged.

Verification (N_CH=2, STABLE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-028 btn_in[0] 0->1 held -> btn_level[0]=1 and press_pulse[0] high one cycle at edge 6 after first sampling edge; channel 1 idle.
REQ-029 btn_in[1] pulses high for 3 cycles, repeated 5 times, 2 cycles low between -> btn_level[1] stays 0, no pulses.
REQ-030 Hold ch0 for 40 cycles after acceptance, AUTO_REPEAT_EN defined -> long_pulse at 20 cycles after press_pulse, repeat_pulse every 5 cycles thereafter; without macro -> repeat_pulse always 0.
REQ-031 Both channels change together -> press_pulse=2'b11 in one cycle; later release -> release_pulse=2'b11 in one cycle, no long_pulse if released before 20 cycles.
REQ-032 rst asserted 2 cycles into a stable ch0 press -> no pulse; held input gives press_pulse 6 edges after rst deasserts.
